keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_scanner_if.sv | 30 +++
 rtl/sync_2ff.sv | 31 +++
 rtl/keypad_scanner.sv | 220 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t       - debounce FSM states (IDLE, DEBOUNCE, PRESSED)
//   scan_result_t - classification of one full scan (EMPTY, SINGLE, MULTI)
//   NUM_ROWS / NUM_COLS - matrix geometry
//   HEX_LEGEND / hex_legend() - raw code (4*row + col) to printed key legend,
//                   used when KEYPAD_HEX_MAP_EN is defined
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_t;

  typedef enum logic [1:0] {
    EMPTY,
    SINGLE,
    MULTI
  } scan_result_t;

  // Entry i (bits 4*i+3:4*i) is the legend of raw code i.
  // Row0: 1 2 3 A, row1: 4 5 6 B, row2: 7 8 9 C, row3: * 0 # D (* = E, # = F).
  localparam logic [63:0] HEX_LEGEND = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] hex_legend(input logic [3:0] raw);
    return HEX_LEGEND[{raw, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key report handshake between the scanner and its consumer.
//   key_code  - code of the last confirmed key
//   key_valid - new key_code available, held until acknowledged
//   key_ack   - consumer acknowledge, sampled at clk edge
//   key_held  - a confirmed key is still pressed
//   overrun   - sticky: a press was confirmed while key_valid was still high
// Modports: master = scanner side, slave = consumer side.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ack
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk  - destination clock
//   rst  - synchronous active-high reset, loads RST_VAL into both stages
//   d    - asynchronous input
//   q    - synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces over whole scans and reports confirmed presses via a valid/ack
// handshake.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   row_n - row drive, active-low, exactly one bit low
//   col_n - column sense, active-low, asynchronous (synchronized internally)
//   kif   - keypad_scanner_if.master: key_code, key_valid, key_ack,
//           key_held, overrun
// Parameters: SCAN_DIV (clk cycles per row step, >= 4),
//             STABLE_SCANS (identical full scans to confirm press/release, >= 1)
// Build option: define KEYPAD_HEX_MAP_EN to report the printed hex legend
//               instead of the raw code 4*row + col.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 20000,
  parameter int STABLE_SCANS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [NUM_ROWS-1:0]      row_n,
  input  logic [NUM_COLS-1:0]      col_n,
  keypad_scanner_if.master         kif
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(STABLE_SCANS + 1);
  localparam int KEYS   = NUM_ROWS * NUM_COLS;

  logic [NUM_COLS-1:0] col_sync;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic                tick;
  logic [1:0]          row_idx_reg;
  logic [NUM_ROWS-1:0] row_n_reg;
  logic [KEYS-1:0]     scan_acc_reg;
  logic [KEYS-1:0]     scan_word;
  logic                scan_done;

  logic [4:0]          key_count;
  logic [3:0]          key_raw;
  scan_result_t        scan_result;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic [3:0]          cand_reg, cand_next;
  logic                confirm;
  logic [3:0]          code_out;

  logic [3:0]          key_code_reg;
  logic                key_valid_reg;
  logic                overrun_reg;

  // Columns are idle-high, so the synchronizer resets to "no key".
  sync_2ff #(
    .WIDTH   (NUM_COLS),
    .RST_VAL ({NUM_COLS{1'b1}})
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_sync)
  );

  assign tick      = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));
  assign scan_done = tick && (row_idx_reg == 2'd3);

  // Scan image with the currently driven row replaced by the live column
  // sample, so the completing tick sees all four rows without waiting a cycle.
  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_scan_word
      assign scan_word[gi*NUM_COLS +: NUM_COLS] =
        (row_idx_reg == 2'(gi)) ? ~col_sync : scan_acc_reg[gi*NUM_COLS +: NUM_COLS];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg  <= '0;
      row_idx_reg  <= 2'd0;
      row_n_reg    <= 4'b1110;
      scan_acc_reg <= '0;
    end else if (tick) begin
      div_cnt_reg  <= '0;
      row_idx_reg  <= row_idx_reg + 2'd1;
      row_n_reg    <= {row_n_reg[NUM_ROWS-2:0], row_n_reg[NUM_ROWS-1]};
      scan_acc_reg <= scan_word;
    end else begin
      div_cnt_reg  <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign row_n = row_n_reg;

  // Count pressed keys and remember the (only meaningful when single) index.
  always_comb begin
    key_count = '0;
    key_raw   = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (scan_word[i]) begin
        key_count = key_count + 5'd1;
        key_raw   = 4'(i);
      end
    end
    if (key_count == 5'd0) begin
      scan_result = EMPTY;
    end else if (key_count == 5'd1) begin
      scan_result = SINGLE;
    end else begin
      scan_result = MULTI;
    end
  end

  // Debounce FSM: cnt_reg counts qualifying scans while debouncing and
  // consecutive empty scans while pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cand_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
    end
  end

  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    confirm    = 1'b0;
    if (scan_done) begin
      case (state_reg)
        IDLE: begin
          if (scan_result == SINGLE) begin
            cand_next = key_raw;
            if (STABLE_SCANS == 1) begin
              confirm    = 1'b1;
              state_next = PRESSED;
              cnt_next   = '0;
            end else begin
              state_next = DEBOUNCE;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          // MULTI counts as empty for press detection.
          if (scan_result != SINGLE) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (key_raw != cand_reg) begin
            cand_next = key_raw;
            cnt_next  = CNT_W'(1);
          end else if (cnt_inc == CNT_W'(STABLE_SCANS)) begin
            confirm    = 1'b1;
            state_next = PRESSED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        PRESSED: begin
          // MULTI counts as non-empty for release detection.
          if (scan_result != EMPTY) begin
            cnt_next = '0;
          end else if (cnt_inc == CNT_W'(STABLE_SCANS)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // A confirm always concerns the key of the completing scan.
`ifdef KEYPAD_HEX_MAP_EN
  assign code_out = hex_legend(key_raw);
`else
  assign code_out = key_raw;
`endif

  // Handshake. An ack in the same cycle as a confirm frees the slot, so the
  // new code is loaded (later assignment wins over the clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (kif.key_ack && key_valid_reg) begin
        key_valid_reg <= 1'b0;
        overrun_reg   <= 1'b0;
      end
      if (confirm) begin
        if (!key_valid_reg || kif.key_ack) begin
          key_code_reg  <= code_out;
          key_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end
    end
  end

  assign kif.key_code  = key_code_reg;
  assign kif.key_valid = key_valid_reg;
  assign kif.key_held  = (state_reg == PRESSED);
  assign kif.overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with SCAN_DIV=4
// and STABLE_SCANS=2 (one full scan = 16 cycles). A keypad model turns the
// pressed-key mask into col_n from the driven row_n. Key patterns change only
// at scan boundaries, so expectations are formed per full scan.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int STABLE_SCANS = 2;
  localparam int SCAN_CYCLES  = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .STABLE_SCANS (STABLE_SCANS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .row_n (row_n),
    .col_n (col_n),
    .kif   (kif.master)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  function automatic logic [3:0] exp_code(input int raw);
`ifdef KEYPAD_HEX_MAP_EN
    return legend[raw];
`else
    return 4'(raw);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (per full scan) ----------------
  bit         m_valid, m_ovr, m_held;
  logic [3:0] m_code;
  int         hist[$];   // recent scan classes: -1 empty, -2 multi, else raw code

  function automatic void model_reset();
    m_valid = 0; m_ovr = 0; m_held = 0; m_code = '0;
    hist.delete();
  endfunction

  function automatic int classify(input logic [15:0] k);
    int cls;
    cls = -1;
    if ($countones(k) > 1) cls = -2;
    else for (int i = 0; i < 16; i++) if (k[i]) cls = i;
    return cls;
  endfunction

  // ack_mode: 0 none, 1 ack at start of scan, 2 ack on the completing edge
  function automatic void model_scan(input logic [15:0] k, input int ack_mode);
    bit conf;
    bit all_same;
    int ck;
    conf = 0;
    ck = classify(k);
    if (ack_mode == 1 && m_valid) begin m_valid = 0; m_ovr = 0; end
    hist.push_back(ck);
    if (hist.size() > STABLE_SCANS) void'(hist.pop_front());
    all_same = (hist.size() == STABLE_SCANS);
    foreach (hist[i]) if (hist[i] != ck) all_same = 0;
    if (!m_held) begin
      if (all_same && ck >= 0) begin
        conf = 1; m_held = 1; hist.delete();
      end
    end else if (all_same && ck == -1) begin
      m_held = 0; hist.delete();
    end
    if (conf) begin
      if (!m_valid || ack_mode == 2) begin
        if (m_valid) m_ovr = 0;
        m_code = exp_code(ck); m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (ack_mode == 2 && m_valid) begin
      m_valid = 0; m_ovr = 0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // Leaves the bench #1 after the last reset edge, i.e. at a scan boundary.
  task automatic do_reset();
    rst = 1'b1;
    keys = '0;
    kif.key_ack = 1'b0;
    @(posedge clk); #1;
    check("rst_row_n", 32'(row_n), 32'h0000000E);
    check("rst_key_code", 32'(kif.key_code), 32'h0);
    check("rst_key_valid", 32'(kif.key_valid), 32'h0);
    check("rst_key_held", 32'(kif.key_held), 32'h0);
    check("rst_overrun", 32'(kif.overrun), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Holds pattern k for one full scan; returns #1 after the completing edge.
  task automatic run_scan(input logic [15:0] k, input int ack_mode);
    keys = k;
    if (ack_mode == 1) kif.key_ack = 1'b1;
    for (int c = 1; c <= SCAN_CYCLES; c++) begin
      @(posedge clk); #1;
      if (ack_mode == 1 && c == 1) kif.key_ack = 1'b0;
      if (ack_mode == 2 && c == SCAN_CYCLES - 1) kif.key_ack = 1'b1;
      if (ack_mode == 2 && c == SCAN_CYCLES) kif.key_ack = 1'b0;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] keys;
    int          ack;
    bit          valid;
    int          code_raw;   // -1: still the reset value 0
    bit          held;
    bit          ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [15:0] k, input int ack, input bit v,
                                  input int code_raw, input bit h, input bit o);
    vec_t e;
    e.keys = k; e.ack = ack; e.valid = v; e.code_raw = code_raw; e.held = h; e.ovr = o;
    vecs.push_back(e);
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rises;
    bit prev_valid;
    logic [15:0] k;
    int prev_single;
    int ack_mode;
    logic [3:0] exp_c;

    kif.key_ack = 1'b0;

    // Reset values and row stepping.
    do_reset();
    repeat (SCAN_DIV - 1) @(posedge clk);
    #1 check("row_n_before_step", 32'(row_n), 32'hE);
    @(posedge clk); #1;
    check("row_n_step1", 32'(row_n), 32'hD);
    repeat (SCAN_DIV) @(posedge clk);
    #1 check("row_n_step2", 32'(row_n), 32'hB);
    repeat (SCAN_DIV) @(posedge clk);
    #1 check("row_n_step3", 32'(row_n), 32'h7);
    repeat (SCAN_DIV) @(posedge clk);
    #1 check("row_n_wrap", 32'(row_n), 32'hE);

    // Directed table: press, ack, release, overrun, multi-key, candidate switch.
    add_vec(16'h0200, 0, 0, -1, 0, 0);
    add_vec(16'h0200, 0, 1,  9, 1, 0);
    add_vec(16'h0200, 1, 0,  9, 1, 0);
    add_vec(16'h0000, 0, 0,  9, 1, 0);
    add_vec(16'h0000, 0, 0,  9, 0, 0);
    add_vec(16'h0080, 0, 0,  9, 0, 0);
    add_vec(16'h0080, 0, 1,  7, 1, 0);
    add_vec(16'h0000, 0, 1,  7, 1, 0);
    add_vec(16'h0000, 0, 1,  7, 0, 0);
    add_vec(16'h1000, 0, 1,  7, 0, 0);
    add_vec(16'h1000, 0, 1,  7, 1, 1);
    add_vec(16'h1000, 1, 0,  7, 1, 0);
    add_vec(16'h0000, 0, 0,  7, 1, 0);
    add_vec(16'h0000, 0, 0,  7, 0, 0);
    add_vec(16'h0003, 0, 0,  7, 0, 0);
    add_vec(16'h0003, 0, 0,  7, 0, 0);
    add_vec(16'h0020, 0, 0,  7, 0, 0);
    add_vec(16'h0040, 0, 0,  7, 0, 0);
    add_vec(16'h0040, 0, 1,  6, 1, 0);
    add_vec(16'h0040, 2, 0,  6, 1, 0);
    add_vec(16'h0000, 0, 0,  6, 1, 0);
    add_vec(16'h0000, 0, 0,  6, 0, 0);
    add_vec(16'h0200, 0, 0,  6, 0, 0);
    add_vec(16'h0200, 2, 1,  9, 1, 0);
    add_vec(16'h0000, 0, 1,  9, 1, 0);
    add_vec(16'h0003, 0, 1,  9, 1, 0);
    add_vec(16'h0000, 0, 1,  9, 1, 0);
    add_vec(16'h0000, 0, 1,  9, 0, 0);

    do_reset();
    foreach (vecs[i]) begin
      run_scan(vecs[i].keys, vecs[i].ack);
      exp_c = (vecs[i].code_raw < 0) ? 4'h0 : exp_code(vecs[i].code_raw);
      check($sformatf("vec%0d_valid", i), 32'(kif.key_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_code", i), 32'(kif.key_code), 32'(exp_c));
      check($sformatf("vec%0d_held", i), 32'(kif.key_held), 32'(vecs[i].held));
      check($sformatf("vec%0d_overrun", i), 32'(kif.overrun), 32'(vecs[i].ovr));
      $display("vec %0d keys=%04h ack=%0d -> valid=%0b code=%0h held=%0b ovr=%0b",
               i, vecs[i].keys, vecs[i].ack, kif.key_valid, kif.key_code,
               kif.key_held, kif.overrun);
    end

    // Bounce on row0/col0, then stable: exactly one key_valid rise.
    do_reset();
    rises = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) keys[0] = ~keys[0];
      @(posedge clk); #1;
      if (kif.key_valid && !prev_valid) rises++;
      prev_valid = kif.key_valid;
    end
    keys = 16'h0001;
    for (int i = 0; i < 3 * SCAN_CYCLES; i++) begin
      @(posedge clk); #1;
      if (kif.key_valid && !prev_valid) rises++;
      prev_valid = kif.key_valid;
    end
    check("bounce_valid_rises", 32'(rises), 32'd1);
    check("bounce_code", 32'(kif.key_code), 32'(exp_code(0)));
    check("bounce_held", 32'(kif.key_held), 32'h1);
    $display("bounce: rises=%0d code=%0h", rises, kif.key_code);

    // Reset midway through debounce restarts from IDLE.
    do_reset();
    run_scan(16'h0200, 0);
    keys = 16'h0200;
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    run_scan(16'h0200, 0);
    check("rst_debounce_no_valid", 32'(kif.key_valid), 32'h0);
    run_scan(16'h0200, 0);
    check("rst_debounce_valid_after_2", 32'(kif.key_valid), 32'h1);
    check("rst_debounce_code", 32'(kif.key_code), 32'(exp_code(9)));
    $display("reset mid-debounce: valid=%0b code=%0h", kif.key_valid, kif.key_code);

    // Reset mid-handshake (key_valid high) is covered by do_reset's checks.
    do_reset();

    // Randomized scans against the reference model.
    prev_single = 5;
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) k = 16'h0000;
      else if (r <= 7) k = 16'(1) << prev_single;
      else if (r == 8) begin
        prev_single = $urandom_range(0, 15);
        k = 16'(1) << prev_single;
      end else begin
        k = 16'(1) << $urandom_range(0, 15);
        k = k | (16'(1) << $urandom_range(0, 15));
      end
      r = $urandom_range(0, 5);
      ack_mode = (r <= 3) ? 0 : (r == 4) ? 1 : 2;
      run_scan(k, ack_mode);
      model_scan(k, ack_mode);
      check($sformatf("rnd%0d_valid", n), 32'(kif.key_valid), 32'(m_valid));
      check($sformatf("rnd%0d_code", n), 32'(kif.key_code), 32'(m_code));
      check($sformatf("rnd%0d_held", n), 32'(kif.key_held), 32'(m_held));
      check($sformatf("rnd%0d_overrun", n), 32'(kif.overrun), 32'(m_ovr));
      check($sformatf("rnd%0d_row_n", n), 32'(row_n), 32'hE);
      $display("rnd %0d keys=%04h ack=%0d -> valid=%0b code=%0h held=%0b ovr=%0b",
               n, k, ack_mode, kif.key_valid, kif.key_code, kif.key_held, kif.overrun);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
